// File: rtl/result_bank.sv
// result_bank: packs 16-bit result words into SLOTS slots, then steps the mux select over them.
// Optional macro RESULT_BANK_CLEAR_EN clears the whole bank on the final drain beat.
module result_bank #(
  parameter int WORD_W = 16,
  parameter int SLOTS  = 16,
  localparam int PW    = $clog2(SLOTS),
  localparam int CW    = $clog2(SLOTS + 1)
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W-1:0]         in_data,
  output logic [WORD_W*SLOTS-1:0]   result,
  output logic [PW-1:0]             sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic [CW-1:0]             count
);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t                         state_q, state_d;
  logic [PW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                  count_q, count_d;
  logic [SLOTS-1:0][WORD_W-1:0]   result_q, result_d;
  assign in_ready  = state_q == FILL;
  assign out_valid = state_q == DRAIN;
  assign sel       = out_valid ? rd_ptr_q : '0;
  assign out_last  = out_valid && rd_ptr_q == PW'(SLOTS - 1);
  assign count     = count_q;
  assign result    = result_q;
  // next state: load a slot per accept while filling, advance the select per beat while draining
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    result_d = result_q;
    if (in_ready && in_valid) begin
      result_d[wr_ptr_q] = in_data;
      wr_ptr_d = wr_ptr_q + PW'(1);
      count_d  = count_q + CW'(1);
      if (wr_ptr_q == PW'(SLOTS - 1)) begin
        state_d  = DRAIN;
        rd_ptr_d = '0;
      end
    end else if (out_valid && out_ready) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (out_last) begin
        state_d  = FILL;
        wr_ptr_d = '0;
        count_d  = '0;
`ifdef RESULT_BANK_CLEAR_EN
        result_d = '0;
`else
        result_d = result_q;
`endif
      end
    end
  end
  // state registers with asynchronous abandon-frame reset
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_result_bank.sv
// tb_result_bank: directed and random stimulus against a slot-array reference model.
module tb_result_bank;
  logic         clk = 1'b0;
  logic         reset_b = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [15:0]  in_data = '0;
  logic         in_ready, out_valid, out_last;
  logic [255:0] result;
  logic [3:0]   sel;
  logic [4:0]   count;
  int errors = 0;
  int checks = 0;
  logic [15:0] m_slot[16];
  int m_n;
  int m_d;
  always #5 clk = ~clk;
  result_bank dut (
    .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .result(result), .sel(sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .count(count)
  );
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] model_bus();
    logic [255:0] r;
    for (int k = 0; k < 16; k++) r[16*k +: 16] = m_slot[k];
    return r;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_slot[k] = '0;
    m_n = 0;
    m_d = 0;
  endtask
  task automatic check_all(input string tag);
    logic drain;
    drain = m_n == 16;
    check({tag, ".in_ready"}, 256'(in_ready), 256'(!drain));
    check({tag, ".out_valid"}, 256'(out_valid), 256'(drain));
    check({tag, ".sel"}, 256'(sel), drain ? 256'(m_d) : 256'(0));
    check({tag, ".out_last"}, 256'(out_last), 256'(drain && m_d == 15));
    check({tag, ".count"}, 256'(count), 256'(m_n));
    check({tag, ".result"}, result, model_bus());
  endtask
  task automatic step(input logic iv, input logic [15:0] d, input logic ordy, input string tag);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
    if (m_n < 16) begin
      if (iv) begin
        m_slot[m_n] = d;
        m_n++;
      end
    end else if (ordy) begin
      if (m_d == 15) begin
        m_n = 0;
        m_d = 0;
`ifdef RESULT_BANK_CLEAR_EN
        for (int k = 0; k < 16; k++) m_slot[k] = '0;
`endif
      end else m_d++;
    end
    check_all(tag);
  endtask
  initial begin
    model_reset();
    #3 check_all("rst_async");
    @(posedge clk);
    #1 check_all("rst_hold");
    reset_b = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0, "idle");
    for (int k = 0; k < 16; k++) step(1'b1, 16'h1000 + 16'(k), 1'b1, "load");
    check("count16", 256'(count), 256'(16));
    for (int k = 0; k < 16; k++) begin
      check("slot_sel", 256'(result[16*sel +: 16]), 256'(16'h1000 + 16'(k)));
      step(1'b0, 16'h0, 1'b1, "drain");
    end
    for (int k = 0; k < 16; k++) step(1'b1, 16'($urandom), 1'b0, "load2");
    for (int k = 0; k < 7; k++) step(1'b0, 16'h0, 1'b1, "drain2");
    for (int k = 0; k < 3; k++) step(1'b1, 16'($urandom), 1'b0, "stall");
    check("stall_sel", 256'(sel), 256'(7));
    for (int k = 0; k < 9; k++) step(1'b0, 16'h0, 1'b1, "resume");
    for (int i = 0; i < 32; i++)
      step(i % 2 == 0, (i / 2) % 2 ? 16'h5A5A : 16'hA5A5, 1'b1, "gap");
    check("gap_full", 256'(out_valid), 256'(1));
    for (int k = 0; k < 16; k++) step(1'b1, 16'($urandom), 1'b1, "drain_iv");
    for (int k = 0; k < 16; k++) step(1'b1, 16'hC000 + 16'(k), 1'b1, "load3");
    for (int k = 0; k < 9; k++) step(1'b0, 16'h0, 1'b1, "drain3");
    in_valid = 1'b0;
    reset_b = 1'b0;
    #2;
    model_reset();
    check_all("rst_mid");
    @(posedge clk);
    #1 reset_b = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, 16'h0B00 + 16'(k), 1'b1, "reload");
    check("reload_slot0", 256'(result[15:0]), 256'(16'h0B00));
    for (int k = 3; k < 16; k++) step(1'b1, 16'h0B00 + 16'(k), 1'b1, "reload");
    for (int k = 0; k < 16; k++) step(1'b0, 16'h0, 1'b1, "drain4");
    for (int k = 0; k < 16; k++) step(1'b1, 16'hFFFF, 1'b1, "ones");
    for (int k = 0; k < 16; k++) step(1'b0, 16'h0, 1'b1, "drain5");
    for (int k = 0; k < 2; k++) step(1'b1, 16'h0001, 1'b1, "part");
`ifdef RESULT_BANK_CLEAR_EN
    check("part_slot15", 256'(result[255:240]), 256'(16'h0000));
`else
    check("part_slot15", 256'(result[255:240]), 256'(16'hFFFF));
`endif
    for (int k = 2; k < 16; k++) step(1'b1, 16'h0002, 1'b1, "part_fill");
    for (int k = 0; k < 16; k++) step(1'b0, 16'h0, 1'b1, "drain6");
    for (int i = 0; i < 1000; i++)
      step(1'($urandom % 2), 16'($urandom), ($urandom % 4) != 0, "rand");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
